// File: rtl/mgmt_apb_bridge_if.sv
// APB bus bundle between the management bridge and the APB root.
// Requester drives the address/control phase; completer answers.
interface mgmt_apb_bridge_if #(
  parameter int DATA_WIDTH = 32,
  parameter int ADDR_WIDTH = 24
);
  logic                    pclk;
  logic                    preset_n;
  logic                    psel;
  logic                    penable;
  logic                    pwrite;
  logic [ADDR_WIDTH-1:0]   paddr;
  logic [DATA_WIDTH-1:0]   pwdata;
  logic [DATA_WIDTH/8-1:0] pstrb;
  logic [2:0]              pprot;
  logic                    pwakeup;
  logic [DATA_WIDTH-1:0]   prdata;
  logic                    pready;
  logic                    pslverr;

  modport requester (
    output pclk, preset_n, psel, penable, pwrite,
    output paddr, pwdata, pstrb, pprot, pwakeup,
    input  prdata, pready, pslverr
  );

  modport completer (
    input  pclk, preset_n, psel, penable, pwrite,
    input  paddr, pwdata, pstrb, pprot, pwakeup,
    output prdata, pready, pslverr
  );
endinterface

// File: rtl/mgmt_apb_bridge.sv
// QSPI byte stream to APB requester bridge with lane auto-increment,
// strobed partial-word writes and sticky error/overflow status.
module mgmt_apb_bridge #(
  parameter int DATA_WIDTH = 32,
  parameter int ADDR_WIDTH = 24
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  start,
  input  logic                  txn_end,
  input  logic                  insn_valid,
  input  logic [7:0]            opcode,
  input  logic [23:0]           addr,
  input  logic                  wr_valid,
  input  logic [7:0]            wr_data,
  input  logic                  rd_ready,
  output logic                  rd_mode,
  output logic                  rd_valid,
  output logic [7:0]            rd_data,
  input  logic                  err_clr,
  output logic                  err,
  output logic [ADDR_WIDTH-1:0] err_addr,
  output logic                  overflow,
  output logic                  busy,
  mgmt_apb_bridge_if.requester  apb
);
  localparam int BYTES = DATA_WIDTH / 8;
  localparam int LB = $clog2(BYTES);
  localparam int AW = ADDR_WIDTH;
  localparam int DW = DATA_WIDTH;
  localparam logic [LB-1:0] LAST = LB'(BYTES - 1);

  typedef enum logic [1:0] {IDLE, SETUP, ACCESS} state_e;

  state_e         state_q, state_d;
  logic           psel_q, psel_d;
  logic           pen_q, pen_d;
  logic           pwr_q, pwr_d;
  logic [AW-1:0]  paddr_q, paddr_d;
  logic [DW-1:0]  pwdata_q, pwdata_d;
  logic [BYTES-1:0] pstrb_q, pstrb_d;
  logic [AW-1:0]  word_q, word_d;
  logic [LB-1:0]  lane_q, lane_d;
  logic           rd_mode_q, rd_mode_d;
  logic           rd_valid_q, rd_valid_d;
  logic [7:0]     rd_data_q, rd_data_d;
  logic [DW-1:0]  hold_q, hold_d;
  logic           hvld_q, hvld_d;
  logic           rq_q, rq_d;
  logic [AW-1:0]  rq_addr_q, rq_addr_d;
  logic [LB-1:0]  rq_lane_q, rq_lane_d;
  logic           cur_rd_q, cur_rd_d;
  logic [LB-1:0]  cur_lane_q, cur_lane_d;
  logic           drop_q, drop_d;
  logic [DW-1:0]  acc_q, acc_d;
  logic [BYTES-1:0] astrb_q, astrb_d;
  logic [AW-1:0]  aaddr_q, aaddr_d;
  logic           pnd_q, pnd_d;
  logic [DW-1:0]  pnd_data_q, pnd_data_d;
  logic [BYTES-1:0] pnd_strb_q, pnd_strb_d;
  logic [AW-1:0]  pnd_addr_q, pnd_addr_d;
  logic           err_q, err_d;
  logic [AW-1:0]  eaddr_q, eaddr_d;
  logic           ovf_q, ovf_d;
  logic           insn_ok, kill, adv, flush;
  logic [DW-1:0]  rsp;

  assign insn_ok = insn_valid && (opcode == 8'h40 || opcode == 8'h41);
  assign kill = start || insn_ok;
  assign rsp = apb.pslverr ? '1 : apb.prdata;

  always_comb begin
    state_d = state_q;
    psel_d = psel_q;
    pen_d = pen_q;
    pwr_d = pwr_q;
    paddr_d = paddr_q;
    pwdata_d = pwdata_q;
    pstrb_d = pstrb_q;
    word_d = word_q;
    lane_d = lane_q;
    rd_mode_d = rd_mode_q;
    rd_valid_d = 1'b0;
    rd_data_d = rd_data_q;
    hold_d = hold_q;
    hvld_d = hvld_q;
    rq_d = rq_q;
    rq_addr_d = rq_addr_q;
    rq_lane_d = rq_lane_q;
    cur_rd_d = cur_rd_q;
    cur_lane_d = cur_lane_q;
    drop_d = drop_q;
    acc_d = acc_q;
    astrb_d = astrb_q;
    aaddr_d = aaddr_q;
    pnd_d = pnd_q;
    pnd_data_d = pnd_data_q;
    pnd_strb_d = pnd_strb_q;
    pnd_addr_d = pnd_addr_q;
    err_d = err_q;
    eaddr_d = eaddr_q;
    ovf_d = ovf_q;
    adv = 1'b0;
    flush = 1'b0;

    if (err_clr) begin
      err_d = 1'b0;
      ovf_d = 1'b0;
    end
    // A new command orphans any read already on the bus.
    if (kill) begin
      rq_d = 1'b0;
      if (state_q != IDLE && cur_rd_q) drop_d = 1'b1;
    end

    if (!kill && rd_mode_q && rd_ready) begin
      adv = 1'b1;
      if (!hvld_q || lane_q == '0) begin
        rq_d = 1'b1;
        rq_addr_d = word_q;
        rq_lane_d = lane_q;
      end else begin
        rd_valid_d = 1'b1;
        rd_data_d = hold_q[{lane_q, 3'b000} +: 8];
      end
    end

    unique case (state_q)
      IDLE: begin
        if (pnd_q) begin
          state_d = SETUP;
          psel_d = 1'b1;
          pen_d = 1'b0;
          pwr_d = 1'b1;
          paddr_d = pnd_addr_q;
          pwdata_d = pnd_data_q;
          pstrb_d = pnd_strb_q;
          pnd_d = 1'b0;
          cur_rd_d = 1'b0;
        end else if (rq_d) begin
          state_d = SETUP;
          psel_d = 1'b1;
          pen_d = 1'b0;
          pwr_d = 1'b0;
          paddr_d = rq_addr_d;
          pstrb_d = '0;
          rq_d = 1'b0;
          cur_rd_d = 1'b1;
          cur_lane_d = rq_lane_d;
        end
      end
      SETUP: begin
        state_d = ACCESS;
        pen_d = 1'b1;
      end
      ACCESS: begin
        if (apb.pready) begin
          state_d = IDLE;
          psel_d = 1'b0;
          pen_d = 1'b0;
          if (apb.pslverr) begin
            err_d = 1'b1;
            if (!err_q) eaddr_d = paddr_q;
          end
          if (cur_rd_q) begin
            if (!drop_d) begin
              hold_d = rsp;
              hvld_d = 1'b1;
              rd_valid_d = 1'b1;
              rd_data_d = rsp[{cur_lane_q, 3'b000} +: 8];
            end
            drop_d = 1'b0;
          end
        end
      end
      default: state_d = IDLE;
    endcase

    if (!kill && wr_valid) begin
      acc_d[{lane_q, 3'b000} +: 8] = wr_data;
      astrb_d[lane_q] = 1'b1;
      aaddr_d = word_q;
      adv = 1'b1;
    end
    flush = !kill && ((wr_valid && lane_q == LAST) ||
                      (txn_end && |astrb_d));
    // The slot may have been freed by a launch this very cycle.
    if (flush) begin
      if (pnd_d) begin
        ovf_d = 1'b1;
      end else begin
        pnd_d = 1'b1;
        pnd_data_d = acc_d;
        pnd_strb_d = astrb_d;
        pnd_addr_d = aaddr_d;
      end
      acc_d = '0;
      astrb_d = '0;
    end

    if (adv) begin
      lane_d = lane_q + LB'(1);
      if (lane_q == LAST) word_d = word_q + AW'(BYTES);
    end
    if (start) rd_mode_d = 1'b0;
    if (insn_ok) begin
      word_d = AW'(addr) & ~AW'(BYTES - 1);
      lane_d = addr[LB-1:0];
      rd_mode_d = (opcode == 8'h40);
      hvld_d = 1'b0;
      acc_d = '0;
      astrb_d = '0;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= IDLE;
      psel_q <= 1'b0;
      pen_q <= 1'b0;
      pwr_q <= 1'b0;
      paddr_q <= '0;
      pwdata_q <= '0;
      pstrb_q <= '0;
      word_q <= '0;
      lane_q <= '0;
      rd_mode_q <= 1'b0;
      rd_valid_q <= 1'b0;
      rd_data_q <= '0;
      hold_q <= '0;
      hvld_q <= 1'b0;
      rq_q <= 1'b0;
      rq_addr_q <= '0;
      rq_lane_q <= '0;
      cur_rd_q <= 1'b0;
      cur_lane_q <= '0;
      drop_q <= 1'b0;
      acc_q <= '0;
      astrb_q <= '0;
      aaddr_q <= '0;
      pnd_q <= 1'b0;
      pnd_data_q <= '0;
      pnd_strb_q <= '0;
      pnd_addr_q <= '0;
      err_q <= 1'b0;
      eaddr_q <= '0;
      ovf_q <= 1'b0;
    end else begin
      state_q <= state_d;
      psel_q <= psel_d;
      pen_q <= pen_d;
      pwr_q <= pwr_d;
      paddr_q <= paddr_d;
      pwdata_q <= pwdata_d;
      pstrb_q <= pstrb_d;
      word_q <= word_d;
      lane_q <= lane_d;
      rd_mode_q <= rd_mode_d;
      rd_valid_q <= rd_valid_d;
      rd_data_q <= rd_data_d;
      hold_q <= hold_d;
      hvld_q <= hvld_d;
      rq_q <= rq_d;
      rq_addr_q <= rq_addr_d;
      rq_lane_q <= rq_lane_d;
      cur_rd_q <= cur_rd_d;
      cur_lane_q <= cur_lane_d;
      drop_q <= drop_d;
      acc_q <= acc_d;
      astrb_q <= astrb_d;
      aaddr_q <= aaddr_d;
      pnd_q <= pnd_d;
      pnd_data_q <= pnd_data_d;
      pnd_strb_q <= pnd_strb_d;
      pnd_addr_q <= pnd_addr_d;
      err_q <= err_d;
      eaddr_q <= eaddr_d;
      ovf_q <= ovf_d;
    end
  end

  assign apb.pclk = clk;
  assign apb.preset_n = rst_n;
  assign apb.psel = psel_q;
  assign apb.penable = pen_q;
  assign apb.pwrite = pwr_q;
  assign apb.paddr = paddr_q;
  assign apb.pwdata = pwdata_q;
  assign apb.pstrb = pstrb_q;
  assign apb.pprot = 3'b000;
  assign apb.pwakeup = 1'b0;

  assign rd_mode = rd_mode_q;
  assign rd_valid = rd_valid_q;
  assign rd_data = rd_data_q;
  assign err = err_q;
  assign err_addr = eaddr_q;
  assign overflow = ovf_q;
  assign busy = (state_q != IDLE) || pnd_q;
endmodule

// File: tb/tb_mgmt_apb_bridge.sv
// Scoreboard bench for mgmt_apb_bridge with a simple APB completer
// model offering wait states and slave errors.
module tb_mgmt_apb_bridge;
  logic        clk;
  logic        rst_n;
  logic        start;
  logic        txn_end;
  logic        insn_valid;
  logic [7:0]  opcode;
  logic [23:0] addr;
  logic        wr_valid;
  logic [7:0]  wr_data;
  logic        rd_ready;
  logic        rd_mode;
  logic        rd_valid;
  logic [7:0]  rd_data;
  logic        err_clr;
  logic        err;
  logic [23:0] err_addr;
  logic        overflow;
  logic        busy;

  mgmt_apb_bridge_if #(.DATA_WIDTH(32), .ADDR_WIDTH(24)) bus ();

  mgmt_apb_bridge #(.DATA_WIDTH(32), .ADDR_WIDTH(24)) dut (
    .clk(clk), .rst_n(rst_n), .start(start), .txn_end(txn_end),
    .insn_valid(insn_valid), .opcode(opcode), .addr(addr),
    .wr_valid(wr_valid), .wr_data(wr_data), .rd_ready(rd_ready),
    .rd_mode(rd_mode), .rd_valid(rd_valid), .rd_data(rd_data),
    .err_clr(err_clr), .err(err), .err_addr(err_addr),
    .overflow(overflow), .busy(busy), .apb(bus)
  );

  typedef struct {
    logic        w;
    logic [23:0] a;
    logic [31:0] d;
    logic [31:0] m;
    logic [3:0]  s;
  } xfer_t;

  xfer_t       ap_q[$];
  logic [7:0]  rb_q[$];
  int total = 0;
  int bad = 0;
  int cnt = 0;
  int acc_cnt = 0;
  int wait_n = 0;
  int setups = 0;
  int setup_cyc = 0;
  int wcnt = 0;
  int rv_count = 0;
  int rv_cyc = 0;
  logic        err_en = 1'b0;
  logic [23:0] err_at = '0;

  function automatic logic [31:0] mem_rd(input logic [23:0] a);
    logic [7:0] b;
    b = a[7:0];
    if (a == 24'h000100) return 32'hDDCCBBAA;
    return {b + 8'h5D, b + 8'h5C, b + 8'h5B, b + 8'h5A};
  endfunction

  assign bus.prdata = mem_rd(bus.paddr);
  assign bus.pready = bus.psel && bus.penable && (acc_cnt >= wait_n);
  assign bus.pslverr = err_en && (bus.paddr == err_at);

  initial clk = 1'b0;
  always #5 clk = ~clk;

  always @(posedge clk) begin
    cnt <= cnt + 1;
    if (bus.psel && bus.penable && !bus.pready) acc_cnt <= acc_cnt + 1;
    else acc_cnt <= 0;
  end

  task automatic chk(input string tag, input logic [63:0] got,
                     input logic [63:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  task automatic monitor();
    xfer_t x;
    logic [7:0] e;
    forever begin
      @(negedge clk);
      if (bus.psel && !bus.penable) begin
        setups++;
        setup_cyc = cnt;
      end
      if (bus.psel && bus.penable && bus.pready) begin
        if (bus.pwrite) wcnt++;
        if (ap_q.size() == 0) begin
          chk("apb_extra", 64'(ap_q.size()), 64'd1);
        end else begin
          x = ap_q.pop_front();
          chk("apb_wr", 64'(bus.pwrite), 64'(x.w));
          chk("apb_addr", 64'(bus.paddr), 64'(x.a));
          chk("apb_strb", 64'(bus.pstrb), 64'(x.s));
          if (x.w) chk("apb_data", 64'(bus.pwdata & x.m), 64'(x.d & x.m));
        end
      end
      if (rd_valid) begin
        rv_count++;
        rv_cyc = cnt;
        if (rb_q.size() == 0) begin
          chk("rd_extra", 64'(rb_q.size()), 64'd1);
        end else begin
          e = rb_q.pop_front();
          chk("rd_data", 64'(rd_data), 64'(e));
        end
      end
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic pulse_start();
    start = 1'b1;
    tick();
    start = 1'b0;
  endtask

  task automatic pulse_end();
    txn_end = 1'b1;
    tick();
    txn_end = 1'b0;
  endtask

  task automatic insn(input logic [7:0] op, input logic [23:0] a);
    insn_valid = 1'b1;
    opcode = op;
    addr = a;
    tick();
    insn_valid = 1'b0;
  endtask

  task automatic wr_byte(input logic [7:0] b, input logic te);
    wr_valid = 1'b1;
    wr_data = b;
    txn_end = te;
    tick();
    wr_valid = 1'b0;
    txn_end = 1'b0;
  endtask

  task automatic rd_byte(input logic [7:0] exp, input int lat);
    int c0;
    int n0;
    rb_q.push_back(exp);
    n0 = rv_count;
    c0 = cnt;
    rd_ready = 1'b1;
    tick();
    rd_ready = 1'b0;
    for (int i = 0; i < 60 && rv_count == n0; i++) tick();
    chk("rd_seen", 64'(rv_count), 64'(n0 + 1));
    if (rv_count == n0 + 1) chk("rd_lat", 64'(rv_cyc - c0), 64'(lat));
  endtask

  task automatic wait_idle();
    for (int i = 0; i < 300 && (busy || ap_q.size() != 0); i++) tick();
    chk("idle", 64'(busy), 64'd0);
  endtask

  function automatic void exp_rd(input logic [23:0] a);
    xfer_t x;
    x.w = 1'b0; x.a = a; x.d = '0; x.m = '0; x.s = '0;
    ap_q.push_back(x);
  endfunction

  function automatic void exp_wr(input logic [23:0] a, input logic [31:0] d,
                                 input logic [31:0] m, input logic [3:0] s);
    xfer_t x;
    x.w = 1'b1; x.a = a; x.d = d; x.m = m; x.s = s;
    ap_q.push_back(x);
  endfunction

  initial begin
    #500000;
    $display("FAIL watchdog total=%0d bad=%0d", total, bad);
    $fatal(1);
  end

  initial begin
    logic [31:0] w;
    int s0;
    int c0;
    int w0;
    rst_n = 1'b0;
    start = 1'b0;
    txn_end = 1'b0;
    insn_valid = 1'b0;
    opcode = '0;
    addr = '0;
    wr_valid = 1'b0;
    wr_data = '0;
    rd_ready = 1'b0;
    err_clr = 1'b0;
    fork
      monitor();
    join_none
    repeat (3) tick();
    chk("rst_apb", 64'({bus.psel, bus.penable, bus.pwrite, bus.pstrb,
                        bus.paddr, bus.pwdata}), 64'd0);
    chk("rst_out", 64'({rd_mode, rd_valid, rd_data, err, err_addr,
                        overflow, busy}), 64'd0);
    rst_n = 1'b1;
    tick();

    pulse_start();
    insn(8'h40, 24'h000102);
    chk("rd_mode", 64'(rd_mode), 64'd1);
    s0 = setups;
    exp_rd(24'h000100);
    rd_byte(8'hCC, 3);
    rd_byte(8'hDD, 1);
    exp_rd(24'h000104);
    w = mem_rd(24'h000104);
    rd_byte(w[7:0], 3);
    chk("rd_setups", 64'(setups - s0), 64'd2);
    pulse_end();

    pulse_start();
    chk("start_clr", 64'(rd_mode), 64'd0);
    insn(8'h41, 24'h000010);
    exp_wr(24'h000010, 32'h44332211, 32'hFFFFFFFF, 4'hF);
    wr_byte(8'h11, 1'b0);
    wr_byte(8'h22, 1'b0);
    wr_byte(8'h33, 1'b0);
    s0 = setups;
    c0 = cnt;
    wr_byte(8'h44, 1'b0);
    for (int i = 0; i < 10 && setups == s0; i++) tick();
    chk("wr_lat", 64'(setup_cyc - c0), 64'd2);
    exp_wr(24'h000014, 32'h00000055, 32'h000000FF, 4'h1);
    wr_byte(8'h55, 1'b1);
    wait_idle();

    wait_n = 5;
    pulse_start();
    insn(8'h40, 24'h000200);
    s0 = setups;
    exp_rd(24'h000200);
    w = mem_rd(24'h000200);
    rd_byte(w[7:0], 8);
    chk("ws_setups", 64'(setups - s0), 64'd1);
    wait_n = 0;
    pulse_end();

    err_en = 1'b1;
    err_at = 24'h000020;
    pulse_start();
    insn(8'h41, 24'h000020);
    exp_wr(24'h000020, 32'h04030201, 32'hFFFFFFFF, 4'hF);
    for (int i = 1; i <= 4; i++) wr_byte(8'(i), 1'b0);
    wait_idle();
    chk("err_set", 64'(err), 64'd1);
    chk("err_addr", 64'(err_addr), 64'h20);
    err_at = 24'h000024;
    exp_wr(24'h000024, 32'h08070605, 32'hFFFFFFFF, 4'hF);
    for (int i = 5; i <= 8; i++) wr_byte(8'(i), 1'b0);
    wait_idle();
    chk("err_keep", 64'(err), 64'd1);
    chk("err_addr2", 64'(err_addr), 64'h20);
    err_clr = 1'b1;
    tick();
    err_clr = 1'b0;
    chk("err_clr", 64'(err), 64'd0);
    err_en = 1'b0;

    wait_n = 20;
    pulse_start();
    insn(8'h41, 24'h000040);
    exp_wr(24'h000040, 32'h04030201, 32'hFFFFFFFF, 4'hF);
    exp_wr(24'h000044, 32'h08070605, 32'hFFFFFFFF, 4'hF);
    w0 = wcnt;
    for (int i = 1; i <= 12; i++) wr_byte(8'(i), 1'b0);
    tick();
    chk("ovf_set", 64'(overflow), 64'd1);
    chk("ovf_busy", 64'(busy), 64'd1);
    wait_idle();
    chk("ovf_writes", 64'(wcnt - w0), 64'd2);
    err_clr = 1'b1;
    tick();
    err_clr = 1'b0;
    chk("ovf_clr", 64'(overflow), 64'd0);

    pulse_start();
    insn(8'h40, 24'h000300);
    rd_ready = 1'b1;
    tick();
    rd_ready = 1'b0;
    for (int i = 0; i < 20 && !(bus.psel && bus.penable); i++) tick();
    chk("rst_acc", 64'(bus.penable), 64'd1);
    #2 rst_n = 1'b0;
    #1;
    chk("rst_psel", 64'(bus.psel), 64'd0);
    chk("rst_busy", 64'(busy), 64'd0);
    repeat (2) tick();
    rst_n = 1'b1;
    wait_n = 0;
    tick();
    pulse_start();
    insn(8'h40, 24'h000000);
    exp_rd(24'h000000);
    w = mem_rd(24'h000000);
    rd_byte(w[7:0], 3);
    pulse_end();
    repeat (3) tick();

    chk("apbq_empty", 64'(ap_q.size()), 64'd0);
    chk("rdq_empty", 64'(rb_q.size()), 64'd0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule

// File: doc/mgmt_apb_bridge.md
# mgmt_apb_bridge

Parametrised bridge between the byte-stream side of the QSPI device interface and a top-level APB requester port, replacing the 16-bit read-only APB path of the management bridge. It supports configurable APB data width, unaligned byte addressing with auto-increment, APB writes with byte strobes and partial-word flush, and sticky error/overflow status. It sits between the QSPI device interface and the chip's APB root.

## Interface
- DATA_WIDTH, 32: APB data width in bits. Legal values are 16, 32 and 64. BYTES = DATA_WIDTH/8.
- ADDR_WIDTH, 24: APB address width in bits, ≤ 24.
- clk  in  1  system clock; also drives apb.pclk.
- rst_n  in  1  reset, asynchronous, active-low; apb.preset_n = rst_n.
- start  in  1  one-cycle pulse on CS# assertion.
- txn_end  in  1  one-cycle pulse on CS# deassertion.
- insn_valid  in  1  opcode/addr valid, one-cycle pulse.
- opcode  in  8  0x40 = APB read, 0x41 = APB write. All other values are ignored.
- addr  in  24  byte address; the low ADDR_WIDTH bits are used.
- wr_valid  in  1  write byte strobe.
- wr_data  in  8  write byte.
- rd_ready  in  1  QSPI requests the next read byte.
- rd_mode  out  1  high during an APB read transaction.
- rd_valid  out  1  read byte valid, one-cycle pulse.
- rd_data  out  8  read byte.
- err_clr  in  1  clears the sticky status bits.
- err  out  1  sticky: pslverr seen.
- err_addr  out  ADDR_WIDTH  paddr of the first errored transfer since the last clear.
- overflow  out  1  sticky: a write word was dropped.
- busy  out  1  APB transfer in flight, or pending write word held.
- apb  APB.requester  DATA_WIDTH  APB bus.
  - pprot = 0, pwakeup = 0.

## Operation
- Address split:
  - word = addr with the low log2(BYTES) bits cleared.
  - lane = addr[log2(BYTES)-1:0].
  - paddr is always word-aligned.
  - Auto-increment: lane+1; when lane wraps to 0, word += BYTES (modulo 2^ADDR_WIDTH).
- APB FSM states: IDLE, SETUP, ACCESS.
  - IDLE → SETUP when a request is ready. In SETUP: psel=1, penable=0.
  - SETUP → ACCESS unconditionally. In ACCESS: psel=1, penable=1.
  - ACCESS → IDLE on pready.
  - All APB outputs are registered.
- insn_valid latches word and lane, sets rd_mode = (opcode == 0x40), invalidates the read holding register, and clears the write accumulator.
- start clears rd_mode.
- Read path:
  - On rd_ready: if the holding register is invalid or lane == 0, issue an APB read (pwrite=0, pstrb=0).
  - On pready: store prdata in the holding register (all-ones if pslverr) and drive rd_data = byte[lane].
  - Otherwise rd_data = holding byte[lane] with no APB access.
  - The address advances on every rd_ready.
- Write path:
  - Each wr_valid places the byte in accumulator lane `lane` and sets strobe bit `lane`; the address then advances.
  - A word is complete when lane wraps to 0, or on txn_end with any strobe bit set.
  - A complete word moves to the single pending slot. The pending slot launches an APB write (pwrite=1, pstrb = strobes) when the FSM is IDLE.
  - If the pending slot is still occupied when a new word completes: drop the new word and set overflow.
- Errors: pready with pslverr sets err; err_addr is captured only if err was previously clear. err_clr clears err and overflow. If an error occurs in the same cycle as err_clr, the error wins.

## Timing
- Reset values:
  - psel, penable, pwrite, pstrb, paddr, pwdata = 0.
  - rd_mode, rd_valid, rd_data, err, err_addr, overflow, busy = 0.
  - FSM = IDLE; holding register invalid; accumulator and pending slot empty.
- Zero-wait APB read: rd_ready in cycle N → SETUP in N+1 → ACCESS in N+2 (pready) → rd_valid in N+3. Each pready wait state adds one cycle.
- Holding-register hit: rd_valid one cycle after rd_ready.
- Write: the completing wr_valid in cycle N → psel in N+2 if the FSM is IDLE.
- txn_end in the same cycle as wr_valid: the byte is included, then flushed.
- start or insn_valid while the APB FSM is busy: the transfer runs to completion.
  - An in-flight read result is discarded, with no rd_valid.
  - A pending write still issues.
  - A new read waits for IDLE.
- A read rd_ready and a pending write issue compete for IDLE in the same cycle: the write has priority.
- Asynchronous reset mid-transfer drops psel immediately.

## Test plan
- Read, DATA_WIDTH=32, opcode 0x40, addr 0x000102, prdata 0xDDCCBBAA, 3 rd_ready → one read at paddr 0x100. Bytes returned: 0xCC, 0xDD, then a second read at 0x104 supplying byte 0.
- Write, opcode 0x41, addr 0x10, bytes 11 22 33 44 55, then txn_end → write at 0x10 with pwdata 0x44332211, pstrb 0xF. Then write at 0x14 with pstrb 0x1, pwdata[7:0] = 0x55.
- pready held low for 5 cycles on a read → rd_valid exactly 5 cycles later than the zero-wait case; no duplicate psel.
- pslverr on a write to 0x20 → err=1, err_addr=0x20. A later error at 0x24 leaves err_addr at 0x20. err_clr → err=0.
- pready stalled for 20 cycles while 12 write bytes arrive → the second complete word is held pending, the third is dropped, overflow=1, and exactly 2 APB writes occur.
- rst_n asserted during ACCESS → psel=0 asynchronously. After release, a read to 0x0 completes normally.
